// File: rtl/sram_2048x32_arbiter_if.sv
// Two-port client bus for the SRAM arbiter: per-port request, lock, write data and read response.
// The slave modport is the arbiter side, the master modport is the requesting client side.
interface sram_2048x32_arbiter_if #(
  parameter int NUM_WORD_ADDR = 11,
  parameter int NUM_BIT       = 32
);
  logic [1:0]               req_i;
  logic [1:0]               we_i;
  logic [1:0]               lock_i;
  logic [NUM_WORD_ADDR-1:0] addr_i  [2];
  logic [NUM_BIT-1:0]       wdata_i [2];
  logic [1:0]               gnt_o;
  logic [1:0]               rvalid_o;
  logic [NUM_BIT-1:0]       rdata_o [2];

  modport slave (
    input  req_i, we_i, lock_i, addr_i, wdata_i,
    output gnt_o, rvalid_o, rdata_o
  );

  modport master (
    output req_i, we_i, lock_i, addr_i, wdata_i,
    input  gnt_o, rvalid_o, rdata_o
  );
endinterface

// File: rtl/sram_2048x32_arbiter.sv
// Two-port arbiter in front of a single-port 2048x32 SRAM with lockable bursts.
// Define SRAM_ARB_ROUND_ROBIN_EN for round-robin IDLE arbitration; otherwise port 0 has fixed priority.
module sram_2048x32_arbiter #(
  parameter int NUM_WORD_ADDR = 11,
  parameter int NUM_BIT       = 32,
  parameter int MAX_BURST     = 16
) (
  input  logic                     CLK,
  input  logic                     RST,
  sram_2048x32_arbiter_if.slave    bus,
  output logic                     CEB,
  output logic                     WEB,
  output logic [NUM_WORD_ADDR-1:0] A,
  output logic [NUM_BIT-1:0]       D,
  input  logic [NUM_BIT-1:0]       Q
);

  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;

  localparam int CNT_W = $clog2(MAX_BURST);
  // The counter holds the number of grants already given to the owner, so the last legal value is MAX_BURST-1.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [1:0]       rd_pend_reg, rd_pend_next;
  logic [1:0]       gnt;
  logic             win;
  logic             own;
  logic             sel;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
  logic rr_reg, rr_next;
`endif

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    gnt        = 2'b00;
    own        = (state_reg == OWN1);
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    rr_next    = rr_reg;
    win        = bus.req_i[1] & (~bus.req_i[0] | rr_reg);
`else
    win        = ~bus.req_i[0];
`endif
    case (state_reg)
      IDLE: begin
        if (|bus.req_i) begin
          gnt = win ? 2'b10 : 2'b01;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
          rr_next = ~win;
`endif
          if (bus.lock_i[win]) begin
            state_next = win ? OWN1 : OWN0;
            cnt_next   = CNT_W'(1);
          end
        end
      end
      OWN0, OWN1: begin
        if (bus.req_i[own]) begin
          gnt = own ? 2'b10 : 2'b01;
          if (!bus.lock_i[own] || cnt_reg == CNT_LAST) begin
            state_next = IDLE;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end else begin
          // Owner went quiet: release immediately rather than hold the SRAM idle.
          state_next = IDLE;
          cnt_next   = '0;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
    if (RST) begin
      gnt = 2'b00;
    end
  end

  assign rd_pend_next = gnt & ~bus.we_i;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      rd_pend_reg <= 2'b00;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
      rr_reg      <= 1'b0;
`endif
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      rd_pend_reg <= rd_pend_next;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
      rr_reg      <= rr_next;
`endif
    end
  end

  assign sel = gnt[1];
  assign CEB = ~|gnt;
  assign WEB = (|gnt) ? ~bus.we_i[sel] : 1'b1;
  assign A   = bus.addr_i[sel];
  assign D   = bus.wdata_i[sel];

  // A read response landing in a reset cycle is dropped, so a read granted just before reset never reports.
  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    assign bus.gnt_o[gi]    = gnt[gi];
    assign bus.rvalid_o[gi] = rd_pend_reg[gi] & ~RST;
    assign bus.rdata_o[gi]  = bus.rvalid_o[gi] ? Q : '0;
  end

endmodule

// File: tb/tb_sram_2048x32_arbiter.sv
// Scoreboard bench for the two-port SRAM arbiter with a behavioural SRAM behind it.
module tb_sram_2048x32_arbiter;
  localparam int AW = 11;
  localparam int DW = 32;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          CEB, WEB;
  logic [AW-1:0] A;
  logic [DW-1:0] D;
  logic [DW-1:0] Q;

  always #5 CLK = ~CLK;

  sram_2048x32_arbiter_if #(.NUM_WORD_ADDR(AW), .NUM_BIT(DW)) bus ();

  sram_2048x32_arbiter #(.NUM_WORD_ADDR(AW), .NUM_BIT(DW), .MAX_BURST(16)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus),
    .CEB (CEB),
    .WEB (WEB),
    .A   (A),
    .D   (D),
    .Q   (Q)
  );

  logic [DW-1:0] sram_mem [2048];
  logic [DW-1:0] exp_mem  [2048];

  always @(posedge CLK) begin
    if (!CEB) begin
      if (!WEB) sram_mem[A] <= D;
      else      Q <= sram_mem[A];
    end
  end

  typedef struct {
    int            port;
    logic [DW-1:0] data;
  } rsp_t;

  rsp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic set_port(input int p, input logic req, input logic we, input logic lock,
                          input logic [AW-1:0] addr, input logic [DW-1:0] data);
    bus.req_i[p]   = req;
    bus.we_i[p]    = we;
    bus.lock_i[p]  = lock;
    bus.addr_i[p]  = addr;
    bus.wdata_i[p] = data;
  endtask

  task automatic idle_ports();
    set_port(0, 1'b0, 1'b0, 1'b0, '0, '0);
    set_port(1, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  // One clock cycle: check the response due now, capture grants, update the model, advance to the next negedge.
  task automatic tick(output logic [1:0] g);
    rsp_t          e;
    rsp_t          r;
    logic [1:0]    ev;
    #1;
    if (RST) begin
      sb.delete();
    end else if (sb.size() > 0 || bus.rvalid_o != 2'b00) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL rsp_unexpected rvalid=%b expected=00", bus.rvalid_o);
      end else begin
        e  = sb.pop_front();
        ev = (e.port == 1) ? 2'b10 : 2'b01;
        if (bus.rvalid_o !== ev || bus.rdata_o[e.port] !== e.data || bus.rdata_o[1-e.port] !== '0) begin
          bad++;
          $display("FAIL rsp_data rvalid=%b rdata0=%h rdata1=%h expected rvalid=%b data=%h",
                   bus.rvalid_o, bus.rdata_o[0], bus.rdata_o[1], ev, e.data);
        end else begin
          $display("rsp port=%0d data=%h ok", e.port, e.data);
        end
      end
    end
    g = bus.gnt_o;
    if (!RST) begin
      for (int p = 0; p < 2; p++) begin
        if (g[p]) begin
          if (bus.we_i[p]) begin
            exp_mem[bus.addr_i[p]] = bus.wdata_i[p];
          end else begin
            r.port = p;
            r.data = exp_mem[bus.addr_i[p]];
            sb.push_back(r);
          end
        end
      end
    end
    @(negedge CLK);
  endtask

  task automatic test_reset();
    logic [1:0] g;
    RST = 1'b1;
    set_port(0, 1'b1, 1'b0, 1'b1, 11'h001, '0);
    set_port(1, 1'b1, 1'b0, 1'b1, 11'h002, '0);
    #1;
    total++;
    if (bus.gnt_o !== 2'b00 || CEB !== 1'b1 || WEB !== 1'b1) begin
      bad++;
      $display("FAIL reset_outputs gnt=%b CEB=%b WEB=%b expected gnt=00 CEB=1 WEB=1", bus.gnt_o, CEB, WEB);
    end
    tick(g);
    tick(g);
    RST = 1'b0;
    idle_ports();
    #1;
    total++;
    if (bus.rvalid_o !== 2'b00) begin
      bad++;
      $display("FAIL reset_rvalid rvalid=%b expected=00", bus.rvalid_o);
    end
    tick(g);
  endtask

  task automatic test_write_read();
    logic [1:0] g;
    set_port(0, 1'b1, 1'b1, 1'b0, 11'h123, 32'hDEADBEEF);
    #1;
    total++;
    if (CEB !== 1'b0 || WEB !== 1'b0 || A !== 11'h123 || D !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL write_pins CEB=%b WEB=%b A=%h D=%h expected 0 0 123 deadbeef", CEB, WEB, A, D);
    end
    tick(g);
    total++;
    if (g !== 2'b01) begin bad++; $display("FAIL write_gnt gnt=%b expected=01", g); end
    set_port(0, 1'b1, 1'b0, 1'b0, 11'h123, '0);
    #1;
    total++;
    if (CEB !== 1'b0 || WEB !== 1'b1 || A !== 11'h123) begin
      bad++;
      $display("FAIL read_pins CEB=%b WEB=%b A=%h expected 0 1 123", CEB, WEB, A);
    end
    tick(g);
    total++;
    if (g !== 2'b01) begin bad++; $display("FAIL read_gnt gnt=%b expected=01", g); end
    idle_ports();
    #1;
    total++;
    if (bus.rdata_o[0] !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL read_data rdata0=%h expected=deadbeef", bus.rdata_o[0]);
    end
    tick(g);
    tick(g);
  endtask

  task automatic test_boundary();
    logic [1:0] g;
    set_port(0, 1'b1, 1'b1, 1'b0, 11'h7FF, 32'hFFFFFFFF);
    tick(g);
    set_port(0, 1'b1, 1'b1, 1'b0, 11'h000, 32'h00000001);
    tick(g);
    set_port(0, 1'b0, 1'b0, 1'b0, '0, '0);
    set_port(1, 1'b1, 1'b0, 1'b0, 11'h7FF, '0);
    tick(g);
    total++;
    if (g !== 2'b10) begin bad++; $display("FAIL boundary_gnt gnt=%b expected=10", g); end
    set_port(1, 1'b1, 1'b0, 1'b0, 11'h000, '0);
    tick(g);
    idle_ports();
    tick(g);
    tick(g);
  endtask

  task automatic test_alternate();
    logic [1:0] g;
    logic [1:0] exp_g;
    for (int i = 0; i < 8; i++) begin
      set_port(0, 1'b1, 1'b1, 1'b0, AW'(8'h10 + i), 32'hA0000000 + i);
      tick(g);
      set_port(0, 1'b1, 1'b1, 1'b0, AW'(8'h20 + i), 32'hB0000000 + i);
      tick(g);
    end
    idle_ports();
    RST = 1'b1;
    tick(g);
    RST = 1'b0;
    tick(g);
    for (int i = 0; i < 8; i++) begin
      set_port(0, 1'b1, 1'b0, 1'b0, AW'(8'h10 + i), '0);
      set_port(1, 1'b1, 1'b0, 1'b0, AW'(8'h20 + i), '0);
`ifdef SRAM_ARB_ROUND_ROBIN_EN
      exp_g = (i % 2 == 1) ? 2'b10 : 2'b01;
`else
      exp_g = 2'b01;
`endif
      tick(g);
      total++;
      if (g !== exp_g) begin
        bad++;
        $display("FAIL alternate_gnt cycle=%0d gnt=%b expected=%b", i, g, exp_g);
      end
    end
    idle_ports();
    tick(g);
  endtask

  task automatic test_burst();
    logic [1:0] g;
    set_port(1, 1'b1, 1'b0, 1'b1, 11'h7FF, '0);
    tick(g);
    total++;
    if (g !== 2'b10) begin bad++; $display("FAIL burst_first gnt=%b expected=10", g); end
    set_port(0, 1'b1, 1'b0, 1'b0, 11'h123, '0);
    for (int i = 1; i < 16; i++) begin
      tick(g);
      total++;
      if (g !== 2'b10) begin bad++; $display("FAIL burst_hold grant=%0d gnt=%b expected=10", i + 1, g); end
    end
    tick(g);
    total++;
    if (g !== 2'b01) begin bad++; $display("FAIL burst_release gnt=%b expected=01", g); end
    idle_ports();
    tick(g);
  endtask

  task automatic test_lock_drop();
    logic [1:0] g;
    set_port(0, 1'b1, 1'b0, 1'b1, 11'h000, '0);
    tick(g);
    total++;
    if (g !== 2'b01) begin bad++; $display("FAIL lock_enter gnt=%b expected=01", g); end
    set_port(0, 1'b0, 1'b0, 1'b0, '0, '0);
    set_port(1, 1'b1, 1'b0, 1'b0, 11'h7FF, '0);
    tick(g);
    total++;
    if (g !== 2'b00) begin bad++; $display("FAIL lock_block gnt=%b expected=00", g); end
    tick(g);
    total++;
    if (g !== 2'b10) begin bad++; $display("FAIL lock_drop_gnt gnt=%b expected=10", g); end
    idle_ports();
    tick(g);
  endtask

  task automatic test_reset_mid();
    logic [1:0] g;
    set_port(0, 1'b1, 1'b0, 1'b1, 11'h123, '0);
    tick(g);
    total++;
    if (g !== 2'b01) begin bad++; $display("FAIL rstmid_gnt gnt=%b expected=01", g); end
    RST = 1'b1;
    set_port(1, 1'b1, 1'b0, 1'b0, 11'h7FF, '0);
    #1;
    total++;
    if (bus.rvalid_o !== 2'b00 || CEB !== 1'b1 || bus.gnt_o !== 2'b00) begin
      bad++;
      $display("FAIL rstmid_abort rvalid=%b CEB=%b gnt=%b expected 00 1 00", bus.rvalid_o, CEB, bus.gnt_o);
    end
    tick(g);
    tick(g);
    RST = 1'b0;
    set_port(0, 1'b0, 1'b0, 1'b0, '0, '0);
    #1;
    total++;
    if (bus.rvalid_o !== 2'b00) begin bad++; $display("FAIL rstmid_rvalid rvalid=%b expected=00", bus.rvalid_o); end
    tick(g);
    total++;
    if (g !== 2'b10) begin bad++; $display("FAIL rstmid_idle gnt=%b expected=10", g); end
    idle_ports();
    tick(g);
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) begin
      sram_mem[i] = '0;
      exp_mem[i]  = '0;
    end
    idle_ports();
    @(negedge CLK);
    test_reset();
    test_write_read();
    test_boundary();
    test_alternate();
    test_burst();
    test_lock_drop();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
